// File: rtl/ins_prefetch_reg_if.sv
// Bus bundle for the instruction prefetch register.
// The fetch side offers words over in_valid/in_ready/insin and can flush.
// The control side consumes the current instruction with advance.
// The prefetch register itself sits on the slave side of this bundle.
interface ins_prefetch_reg_if #(
  parameter int INS_W = 16,
  parameter int OP_W  = 4,
  parameter int DEPTH = 4
);
  localparam int ADDR_W = INS_W - OP_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [INS_W-1:0]  insin;
  logic              advance;
  logic              out_valid;
  logic [OP_W-1:0]   opcode;
  logic [ADDR_W-1:0] address;
  logic [CNT_W-1:0]  count;

  // Fetch unit and control unit together, as seen from outside the register
  modport master (
    output flush,
    output in_valid,
    output insin,
    output advance,
    input  in_ready,
    input  out_valid,
    input  opcode,
    input  address,
    input  count
  );

  // The prefetch register
  modport slave (
    input  flush,
    input  in_valid,
    input  insin,
    input  advance,
    output in_ready,
    output out_valid,
    output opcode,
    output address,
    output count
  );
endinterface

// File: rtl/ins_prefetch_reg.sv
// Instruction register with a DEPTH-entry prefetch queue.
// Fetched words are queued in a small circular FIFO. The oldest word is moved
// into an output register, where it is presented as opcode/address fields.
// The control unit consumes that word with advance. A jump flushes both the
// queue and the output register.
// The write path has no bypass: a word always spends at least one edge in the
// FIFO before it reaches the output register. This keeps in_ready a function
// of registered state only.
module ins_prefetch_reg #(
  parameter int INS_W = 16,
  parameter int OP_W  = 4,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  ins_prefetch_reg_if.slave bus
);

  localparam int ADDR_W = INS_W - OP_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Queue storage and bookkeeping
  logic [INS_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;

  // Output (instruction) register
  logic              out_valid_q;
  logic [OP_W-1:0]   opcode_q;
  logic [ADDR_W-1:0] address_q;

  // Per-edge decisions
  logic              not_full;
  logic              not_empty;
  logic              push;
  logic              pop;
  logic              drop;
  logic [INS_W-1:0]  head_word;

  // Decide what happens at the next edge; flush overrides every other action
  always_comb begin
    not_full  = (count_q != FULL_CNT);
    not_empty = (count_q != '0);
    push      = 1'b0;
    pop       = 1'b0;
    drop      = 1'b0;
    head_word = mem[rd_ptr];
    if (!bus.flush) begin
      push = bus.in_valid & not_full;
      pop  = not_empty & (~out_valid_q | bus.advance);
      drop = ~not_empty & out_valid_q & bus.advance;
    end
  end

  // Queue storage: written only on an accepted word, never reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.insin;
    end
  end

  // Write pointer: wraps naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer: steps each time the head word moves to the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
    end else if (bus.flush) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (bus.flush) begin
      count_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Valid flag of the output register; set on a pop, cleared when the last word is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (pop) begin
      out_valid_q <= 1'b1;
    end else if (drop) begin
      out_valid_q <= 1'b0;
    end
  end

  // Opcode/address fields; a drained register keeps its stale contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q  <= '0;
      address_q <= '0;
    end else if (bus.flush) begin
      opcode_q  <= '0;
      address_q <= '0;
    end else if (pop) begin
      opcode_q  <= head_word[INS_W-1 -: OP_W];
      address_q <= head_word[ADDR_W-1:0];
    end
  end

  // Drive the bundle from registered state only
  always_comb begin
    bus.in_ready  = not_full;
    bus.out_valid = out_valid_q;
    bus.opcode    = opcode_q;
    bus.address   = address_q;
    bus.count     = count_q;
  end

endmodule
